// File: rtl/exception_sequencer.sv
// Exception entry sequencer: records cause/EPC, fetches the handler byte through
// the vector-address mux, then strobes a one-cycle PC load of the handler address.
module exception_sequencer #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_req,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    input  logic [31:0] pc_in,
    input  logic [7:0]  mem_data,
    output logic [3:0]  exc_sel,
    output logic        mem_rd,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic [31:0] pc_next,
    output logic        pc_load,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic        any_cause;

    // Fixed priority: opcode over overflow over divzero.
    function automatic logic [1:0] encode_cause(input logic op, input logic ov, input logic dz);
        logic [1:0] code;
        code = 2'd0;
        if (op)      code = 2'd1;
        else if (ov) code = 2'd2;
        else if (dz) code = 2'd3;
        return code;
    endfunction

    assign any_cause = exc_opcode | exc_overflow | exc_divzero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            epc_q     <= 32'd0;
            cause_q   <= 2'd0;
            pc_next_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            pc_next_q <= pc_next_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        pc_next_d = pc_next_q;
        exc_sel   = 4'b0000;
        mem_rd    = 1'b0;
        pc_load   = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                if (exc_req && any_cause) begin
                    cause_d = encode_cause(exc_opcode, exc_overflow, exc_divzero);
                    epc_d   = pc_in - 32'd4;
                    cnt_d   = CNT_INIT;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Selector code equals the cause code, so the mux picks 253/254/255.
                exc_sel = {2'b00, cause_q};
                mem_rd  = 1'b1;
                busy    = 1'b1;
                if (cnt_q == 4'd0) begin
                    pc_next_d = {24'b0, mem_data};
                    state_d   = LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            LOAD: begin
                pc_load = 1'b1;
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign epc     = epc_q;
    assign cause   = cause_q;
    assign pc_next = pc_next_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: one instance with MEM_LAT=2 and one
// with MEM_LAT=1 for back-to-back sequencing.
module tb_exception_sequencer;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_req, a_op, a_ov, a_dz;
    logic [31:0] a_pc;
    logic [7:0]  a_mem;
    logic [3:0]  a_sel;
    logic        a_rd, a_pcl, a_busy;
    logic [31:0] a_epc, a_pcn;
    logic [1:0]  a_cause;

    logic        b_req, b_op, b_ov, b_dz;
    logic [31:0] b_pc;
    logic [7:0]  b_mem;
    logic [3:0]  b_sel;
    logic        b_rd, b_pcl, b_busy;
    logic [31:0] b_epc, b_pcn;
    logic [1:0]  b_cause;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exception_sequencer #(.MEM_LAT(2)) dut_a (
        .clk(clk), .reset(reset), .exc_req(a_req), .exc_opcode(a_op),
        .exc_overflow(a_ov), .exc_divzero(a_dz), .pc_in(a_pc), .mem_data(a_mem),
        .exc_sel(a_sel), .mem_rd(a_rd), .epc(a_epc), .cause(a_cause),
        .pc_next(a_pcn), .pc_load(a_pcl), .busy(a_busy)
    );

    exception_sequencer #(.MEM_LAT(1)) dut_b (
        .clk(clk), .reset(reset), .exc_req(b_req), .exc_opcode(b_op),
        .exc_overflow(b_ov), .exc_divzero(b_dz), .pc_in(b_pc), .mem_data(b_mem),
        .exc_sel(b_sel), .mem_rd(b_rd), .epc(b_epc), .cause(b_cause),
        .pc_next(b_pcn), .pc_load(b_pcl), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic a_drive(input logic req, input logic op, input logic ov, input logic dz,
                           input logic [31:0] pc, input logic [7:0] mem);
        a_req = req; a_op = op; a_ov = ov; a_dz = dz; a_pc = pc; a_mem = mem;
    endtask

    task automatic b_drive(input logic req, input logic op, input logic ov, input logic dz,
                           input logic [31:0] pc, input logic [7:0] mem);
        b_req = req; b_op = op; b_ov = ov; b_dz = dz; b_pc = pc; b_mem = mem;
    endtask

    task automatic a_all_zero(input string tag);
        chk({tag, "_sel"},   32'(a_sel),   32'h0);
        chk({tag, "_rd"},    32'(a_rd),    32'h0);
        chk({tag, "_epc"},   a_epc,        32'h0);
        chk({tag, "_cause"}, 32'(a_cause), 32'h0);
        chk({tag, "_pcn"},   a_pcn,        32'h0);
        chk({tag, "_pcl"},   32'(a_pcl),   32'h0);
        chk({tag, "_busy"},  32'(a_busy),  32'h0);
    endtask

    initial begin
        reset = 1'b1;
        a_drive(0, 0, 0, 0, 32'h0, 8'h0);
        b_drive(0, 0, 0, 0, 32'h0, 8'h0);
        #1;
        a_all_zero("rst");
        chk("rst_b_busy", 32'(b_busy), 32'h0);
        chk("rst_b_pcn",  b_pcn,       32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single overflow exception, MEM_LAT=2
        @(negedge clk);
        a_drive(1, 0, 1, 0, 32'h0000_0040, 8'h7C);
        @(negedge clk);
        a_drive(0, 0, 0, 0, 32'h0000_0040, 8'h7C);
        chk("ov_t1_sel",   32'(a_sel),   32'h2);
        chk("ov_t1_rd",    32'(a_rd),    32'h1);
        chk("ov_t1_busy",  32'(a_busy),  32'h1);
        chk("ov_t1_pcl",   32'(a_pcl),   32'h0);
        chk("ov_t1_epc",   a_epc,        32'h0000_003C);
        chk("ov_t1_cause", 32'(a_cause), 32'h2);
        chk("ov_t1_pcn",   a_pcn,        32'h0);
        @(negedge clk);
        chk("ov_t2_sel",   32'(a_sel),   32'h2);
        chk("ov_t2_rd",    32'(a_rd),    32'h1);
        chk("ov_t2_pcl",   32'(a_pcl),   32'h0);
        @(negedge clk);
        chk("ov_t3_pcl",   32'(a_pcl),   32'h1);
        chk("ov_t3_pcn",   a_pcn,        32'h0000_007C);
        chk("ov_t3_sel",   32'(a_sel),   32'h0);
        chk("ov_t3_rd",    32'(a_rd),    32'h0);
        chk("ov_t3_busy",  32'(a_busy),  32'h1);
        @(negedge clk);
        chk("ov_t4_pcl",   32'(a_pcl),   32'h0);
        chk("ov_t4_busy",  32'(a_busy),  32'h0);
        chk("ov_t4_pcn",   a_pcn,        32'h0000_007C);

        // All causes set: opcode wins; a second request during FETCH is ignored
        a_drive(1, 1, 1, 1, 32'h0000_0100, 8'h11);
        @(negedge clk);
        chk("pri_sel",   32'(a_sel),   32'h1);
        chk("pri_cause", 32'(a_cause), 32'h1);
        chk("pri_epc",   a_epc,        32'h0000_00FC);
        a_drive(1, 0, 0, 1, 32'h0000_0999, 8'h11);
        @(negedge clk);
        a_drive(0, 0, 0, 0, 32'h0, 8'h11);
        chk("ign_cause", 32'(a_cause), 32'h1);
        chk("ign_epc",   a_epc,        32'h0000_00FC);
        chk("ign_sel",   32'(a_sel),   32'h1);
        @(negedge clk);
        chk("pri_pcl",   32'(a_pcl),   32'h1);
        chk("pri_pcn",   a_pcn,        32'h0000_0011);
        @(negedge clk);
        chk("ign_pcl1",  32'(a_pcl),   32'h0);
        chk("ign_busy1", 32'(a_busy),  32'h0);
        @(negedge clk);
        chk("ign_pcl2",  32'(a_pcl),   32'h0);
        chk("ign_busy2", 32'(a_busy),  32'h0);

        // Divzero alone, with EPC wrapping below zero
        a_drive(1, 0, 0, 1, 32'h0000_0000, 8'hA5);
        @(negedge clk);
        a_drive(0, 0, 0, 0, 32'h0, 8'hA5);
        chk("dz_sel",   32'(a_sel),   32'h3);
        chk("dz_cause", 32'(a_cause), 32'h3);
        chk("dz_epc",   a_epc,        32'hFFFF_FFFC);
        @(negedge clk);
        @(negedge clk);
        chk("dz_pcl",   32'(a_pcl),   32'h1);
        chk("dz_pcn",   a_pcn,        32'h0000_00A5);
        @(negedge clk);

        // Request without any cause, then cause bits without a request
        a_drive(1, 0, 0, 0, 32'h0000_0500, 8'h00);
        @(negedge clk);
        chk("nocause_busy",  32'(a_busy),  32'h0);
        chk("nocause_epc",   a_epc,        32'hFFFF_FFFC);
        chk("nocause_cause", 32'(a_cause), 32'h3);
        a_drive(0, 1, 1, 1, 32'h0000_0600, 8'h00);
        @(negedge clk);
        chk("noreq_busy", 32'(a_busy), 32'h0);
        chk("noreq_epc",  a_epc,       32'hFFFF_FFFC);
        a_drive(0, 0, 0, 0, 32'h0, 8'h00);

        // Reset asserted during the first FETCH cycle
        a_drive(1, 1, 0, 0, 32'h0000_0020, 8'h33);
        @(negedge clk);
        a_drive(0, 0, 0, 0, 32'h0, 8'h33);
        chk("rmid_pre_busy", 32'(a_busy), 32'h1);
        reset = 1'b1;
        #1;
        a_all_zero("rmid");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rmid_post%0d_pcl", i),  32'(a_pcl),  32'h0);
            chk($sformatf("rmid_post%0d_busy", i), 32'(a_busy), 32'h0);
        end
        a_drive(1, 0, 1, 0, 32'h0000_0080, 8'h55);
        @(negedge clk);
        a_drive(0, 0, 0, 0, 32'h0, 8'h55);
        chk("fresh_sel", 32'(a_sel), 32'h2);
        chk("fresh_epc", a_epc,      32'h0000_007C);
        @(negedge clk);
        @(negedge clk);
        chk("fresh_pcl", 32'(a_pcl), 32'h1);
        chk("fresh_pcn", a_pcn,      32'h0000_0055);
        @(negedge clk);
        chk("fresh_done", 32'(a_busy), 32'h0);

        // Back-to-back requests on the MEM_LAT=1 instance
        b_drive(1, 1, 0, 0, 32'h0000_0010, 8'h21);
        @(negedge clk);
        b_drive(0, 0, 0, 0, 32'h0, 8'h21);
        chk("b2b_t1_sel", 32'(b_sel), 32'h1);
        chk("b2b_t1_rd",  32'(b_rd),  32'h1);
        chk("b2b_t1_pcl", 32'(b_pcl), 32'h0);
        @(negedge clk);
        chk("b2b_t2_pcl", 32'(b_pcl), 32'h1);
        chk("b2b_t2_pcn", b_pcn,      32'h0000_0021);
        chk("b2b_t2_epc", b_epc,      32'h0000_000C);
        @(negedge clk);
        chk("b2b_t3_busy", 32'(b_busy), 32'h0);
        chk("b2b_t3_pcl",  32'(b_pcl),  32'h0);
        b_drive(1, 0, 0, 1, 32'h0000_0030, 8'h42);
        @(negedge clk);
        b_drive(0, 0, 0, 0, 32'h0, 8'h42);
        chk("b2b_t4_sel",   32'(b_sel),   32'h3);
        chk("b2b_t4_cause", 32'(b_cause), 32'h3);
        chk("b2b_t4_pcn",   b_pcn,        32'h0000_0021);
        @(negedge clk);
        chk("b2b_t5_pcl", 32'(b_pcl), 32'h1);
        chk("b2b_t5_pcn", b_pcn,      32'h0000_0042);
        chk("b2b_t5_epc", b_epc,      32'h0000_002C);
        @(negedge clk);
        chk("b2b_t6_pcl",  32'(b_pcl),  32'h0);
        chk("b2b_t6_busy", 32'(b_busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/exception_sequencer.md
# exception_sequencer

Multicycle-datapath block that runs the exception entry sequence. When the control unit strobes an exception check with one or more cause flags set, it:
- records the cause and EPC;
- drives the exception-vector selector on the memory-address mux for a fixed memory latency;
- captures the handler byte returned by memory;
- issues a one-cycle PC load with the zero-extended handler address.

It is the controlling end of the vector-address mux: it produces the selector that the mux decodes into 253/254/255.

## Interface

Parameters:
- MEM_LAT, 2, memory read latency in cycles from address presented to data valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- exc_req  in  1  single-cycle strobe from control unit; cause flags are sampled only in this cycle.
- exc_opcode  in  1  invalid-opcode cause.
- exc_overflow  in  1  arithmetic-overflow cause.
- exc_divzero  in  1  divide-by-zero cause.
- pc_in  in  32  current PC, already incremented past the faulting instruction.
- mem_data  in  8  byte read from memory.
- exc_sel  out  4  selector to the address mux: 0000 selects ALUout, 0001 selects 253, 0010 selects 254, 0011 selects 255.
- mem_rd  out  1  memory read enable.
- epc  out  32  exception program counter register.
- cause  out  2  last accepted cause code: 1 opcode, 2 overflow, 3 divzero, 0 none since reset.
- pc_next  out  32  handler address, {24'b0, captured byte}.
- pc_load  out  1  one-cycle PC write strobe.
- busy  out  1  high while a sequence is in progress (all non-IDLE states).

## Operation

State machine states:
- **IDLE**
  - exc_sel=0000, mem_rd=0, pc_load=0, busy=0.
  - On exc_req with at least one cause set:
    - code = opcode ? 1 : overflow ? 2 : divzero ? 3 (fixed priority).
    - cause <= code.
    - epc <= pc_in - 32'd4, modulo 2^32.
    - Load wait counter with MEM_LAT-1.
    - Go to FETCH.
  - exc_req with no cause set: ignored, no register changes.
- **FETCH**
  - exc_sel={2'b00, cause}, mem_rd=1, busy=1.
  - Counter decrements each cycle.
  - In the cycle the counter reads 0: pc_next <= {24'b0, mem_data}, then go to LOAD.
- **LOAD**
  - exc_sel=0000, mem_rd=0, pc_load=1, busy=1.
  - Next state IDLE.

General rules:
- exc_req while busy: ignored entirely; cause, epc and pc_next are not disturbed and no request is queued.
- Cause bits outside the exc_req cycle: no effect.
- epc, cause and pc_next hold their values between sequences.

## Timing

- Reset, asynchronous: state IDLE, counter 0; all outputs 0 (exc_sel=0000, mem_rd=0, epc=0, cause=0, pc_next=0, pc_load=0, busy=0).
- Reset asserted mid-sequence: the sequence aborts immediately and no pc_load is issued after reset releases.
- exc_req accepted in cycle T:
  - Cycles T+1..T+MEM_LAT: FETCH, exc_sel and mem_rd asserted.
  - mem_data is sampled at the rising edge ending cycle T+MEM_LAT.
  - Cycle T+MEM_LAT+1: LOAD, pc_load=1, pc_next valid.
  - Cycle T+MEM_LAT+2: IDLE; a new exc_req is accepted in this cycle.
- Total occupancy: MEM_LAT+1 busy cycles.
- epc and cause are valid from cycle T+1.
- pc_next changes only at the capture edge.
- pc_load is never high for more than one consecutive cycle.

## Test plan

- **Single overflow** (MEM_LAT=2): exc_req with overflow=1 at T, pc_in=0x00000040; mem_data=0x7C during FETCH.
  - Required: exc_sel=0010 and mem_rd=1 in T+1..T+2.
  - Required: pc_load=1 with pc_next=0x0000007C at T+3.
  - Required: epc=0x0000003C, cause=2.
- **Priority**: opcode, overflow and divzero all set with exc_req.
  - Required: exc_sel=0001, cause=1.
  - Required: divzero alone gives exc_sel=0011, cause=3.
- **Ignored requests**:
  - exc_req with no cause set: busy stays 0, epc unchanged.
  - Second exc_req during FETCH: no extra pc_load, cause/epc unchanged.
- **Wrap**: pc_in=0x00000000 with a divzero exception -> epc=0xFFFFFFFC.
- **Reset mid-FETCH**: assert reset during the first FETCH cycle.
  - Required: all outputs 0 immediately; no pc_load in the following 5 cycles.
  - Required: a fresh request then completes normally.
- **Back-to-back with MEM_LAT=1**:
  - Request accepted at T -> pc_load at T+2.
  - New request accepted at T+3 -> pc_load at T+5, with the new handler byte.
